// File: rtl/serial_magcomp.sv
// Multi-cycle WIDTH-bit unsigned magnitude comparator. The operands are walked MSB-first,
// two bits per clock, through one twobitcomp stage, and the walk stops at the first unequal slice.

module twobitcomp (
  input  logic x1,
  input  logic x0,
  input  logic y1,
  input  logic y0,
  output logic g,
  output logic l,
  output logic e
);
  always_comb begin
    g = ({x1, x0} >  {y1, y0});
    l = ({x1, x0} <  {y1, y0});
    e = ({x1, x0} == {y1, y0});
  end
endmodule

module serial_magcomp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);
  localparam int NS = WIDTH / 2;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ra, rb;
  logic [IW-1:0]    idx;
  logic [1:0]       slice_a [NS];
  logic [1:0]       slice_b [NS];
  logic [1:0]       cur_a, cur_b;
  logic             g, l, e, last;

  // Split the held operands into 2-bit slices so the active one can be picked by idx.
  always_comb begin
    for (int unsigned s = 0; s < NS; s++) begin
      slice_a[s] = ra[2*s +: 2];
      slice_b[s] = rb[2*s +: 2];
    end
    cur_a = slice_a[idx];
    cur_b = slice_b[idx];
    last  = (idx == '0);
  end

  twobitcomp u_stage (
    .x1(cur_a[1]),
    .x0(cur_a[0]),
    .y1(cur_b[1]),
    .y0(cur_b[0]),
    .g (g),
    .l (l),
    .e (e)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (g || l || (e && last)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ra   <= '0;
      rb   <= '0;
      idx  <= '0;
      done <= 1'b0;
      gt   <= 1'b0;
      lt   <= 1'b0;
      eq   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            idx <= IW'(NS - 1);
            gt  <= 1'b0;
            lt  <= 1'b0;
            eq  <= 1'b0;
          end
        end
        RUN: begin
          if (g) begin
            gt   <= 1'b1;
            done <= 1'b1;
          end else if (l) begin
            lt   <= 1'b1;
            done <= 1'b1;
          end else if (last) begin
            eq   <= 1'b1;
            done <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_magcomp.sv
// Bench for serial_magcomp: vector table, directed multi-cycle sequences and random operands
// checked against a prefix-comparison reference model.

module tb_serial_magcomp;
  localparam int WIDTH = 8;
  localparam int NS    = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst_n, start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, gt, lt, eq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_magcomp #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .gt   (gt),
    .lt   (lt),
    .eq   (eq)
  );

  typedef struct {
    string            name;
    logic [WIDTH-1:0] va, vb;
    logic             egt, elt, eeq;
    int               elat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: compare ever-longer MSB prefixes; the first unequal prefix decides.
  function automatic void ref_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  output logic rg, output logic rl, output logic re,
                                  output int lat);
    int unsigned px, py;
    rg = 1'b0; rl = 1'b0; re = 1'b1; lat = NS;
    for (int k = 1; k <= NS; k++) begin
      px = 32'(x) >> (WIDTH - 2*k);
      py = 32'(y) >> (WIDTH - 2*k);
      if (px != py) begin
        rg = (px > py); rl = (px < py); re = 1'b0; lat = k;
        return;
      end
    end
  endfunction

  task automatic run_cmp(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic egt, input logic elt, input logic eeq, input int elat);
    int lat = 99;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, " busy_after_accept"}, 32'(busy), 32'(1));
    check({name, " cleared_while_busy"}, 32'({gt, lt, eq, done}), 32'(0));
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (done) begin
        lat = j;
        break;
      end
    end
    check({name, " latency"}, 32'(lat), 32'(elat));
    check({name, " gt_lt_eq"}, 32'({gt, lt, eq}), 32'({egt, elt, eeq}));
    check({name, " busy_at_done"}, 32'(busy), 32'(0));
  endtask

  initial begin
    vec_t             tbl [8];
    logic [WIDTH-1:0] va, vb;
    logic             rg, rl, re;
    int               rlat, lat;
    bit               seen;

    tbl[0] = '{"msb_gt",    8'hC3, 8'h43, 1'b1, 1'b0, 1'b0, 1};
    tbl[1] = '{"lsb_lt",    8'h56, 8'h57, 1'b0, 1'b1, 1'b0, 4};
    tbl[2] = '{"equal_a5",  8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 4};
    tbl[3] = '{"msb_lt",    8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1};
    tbl[4] = '{"slice2_gt", 8'h31, 8'h21, 1'b1, 1'b0, 1'b0, 2};
    tbl[5] = '{"slice3_gt", 8'h4C, 8'h48, 1'b1, 1'b0, 1'b0, 3};
    tbl[6] = '{"equal_ff",  8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 4};
    tbl[7] = '{"msb_7f_80", 8'h7F, 8'h80, 1'b0, 1'b1, 1'b0, 1};

    // Reset held for two edges with start asserted.
    rst_n = 1'b0; start = 1'b1; a = 8'hC3; b = 8'h43;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({busy, done, gt, lt, eq}), 32'(0));
    rst_n = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", 32'({busy, done, gt, lt, eq}), 32'(0));

    foreach (tbl[i])
      run_cmp(tbl[i].name, tbl[i].va, tbl[i].vb, tbl[i].egt, tbl[i].elt, tbl[i].eeq, tbl[i].elat);

    // Start pulsed while busy with new operands, inputs changed again afterwards.
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(negedge clk);
    check("ign busy", 32'(busy), 32'(1));
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    a = 8'h55; b = 8'hAA; start = 1'b0;
    lat = 99;
    if (done) lat = 1;
    for (int j = 2; j <= 20 && lat == 99; j++) begin
      @(negedge clk);
      if (done) lat = j;
    end
    check("ign latency", 32'(lat), 32'(2));
    check("ign gt_lt_eq", 32'({gt, lt, eq}), 32'(3'b010));
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy || done) seen = 1'b1;
    end
    check("ign no_requeue", 32'(seen), 32'(0));

    // Continuous start: accept, 4 RUN cycles, re-accept on the edge after done.
    @(negedge clk);
    a = 8'h01; b = 8'h00; start = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      check($sformatf("b2b done j=%0d", j), 32'(done), 32'((j % 5) == 4));
      if ((j % 5) == 4) check($sformatf("b2b gt j=%0d", j), 32'({gt, lt, eq}), 32'(3'b100));
      if ((j % 5) == 0) check($sformatf("b2b reaccept j=%0d", j), 32'({busy, gt, lt, eq}), 32'(4'b1000));
    end
    start = 1'b0;
    for (int j = 0; j < 10 && busy; j++) @(negedge clk);
    @(negedge clk);
    check("b2b drained", 32'(busy), 32'(0));

    // Reset in the middle of an equal-operand comparison.
    @(negedge clk);
    a = 8'h3C; b = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset outputs", 32'({busy, done, gt, lt, eq}), 32'(0));
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("midreset no_done", 32'(seen), 32'(0));

    // All 16 MSB-slice combinations with random lower bits.
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        va = {2'(x), 6'($urandom)};
        vb = {2'(y), (x == y) ? va[5:0] ^ 6'($urandom_range(0, 3)) : 6'($urandom)};
        ref_cmp(va, vb, rg, rl, re, rlat);
        run_cmp($sformatf("sweep x=%0d y=%0d", x, y), va, vb, rg, rl, re, rlat);
      end
    end

    // Random operands, biased towards long common prefixes.
    for (int i = 0; i < 30; i++) begin
      va = 8'($urandom);
      vb = ($urandom_range(0, 1) == 1) ? va ^ 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      if (i % 7 == 0) vb = va;
      ref_cmp(va, vb, rg, rl, re, rlat);
      run_cmp($sformatf("rand%0d %02h_%02h", i, va, vb), va, vb, rg, rl, re, rlat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
